// File: rtl/fft16_pkg.sv
// Shared constants and types for the memory-based 16-point radix-2 DIT FFT.
// The datapath top reuses the latency defaults so that it stays in step with the sequencer.
package fft16_pkg;

  localparam int N      = 16;
  localparam int LOG2N  = 4;
  localparam int NBF    = 8;
  localparam int ADDR_W = 4;
  localparam int TW_W   = 3;

  localparam int RD_LAT_DEF = 1;
  localparam int BF_LAT_DEF = 13;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/fft16_addr_gen.sv
// Combinational butterfly address generator.
// Maps (stage, butterfly index) to the operand pair and the twiddle index.
module fft16_addr_gen
  import fft16_pkg::*;
(
  input  logic [1:0]        stage,
  input  logic [2:0]        k,
  output logic [ADDR_W-1:0] a,
  output logic [ADDR_W-1:0] b,
  output logic [TW_W-1:0]   tw_idx
);

  logic [ADDR_W-1:0] span;
  logic [ADDR_W-1:0] pos;
  logic [ADDR_W-1:0] grp;

  // pos < span, so grp*2*span and pos occupy disjoint bits
  always_comb begin
    span   = ADDR_W'(1) << stage;
    pos    = {1'b0, k} & (span - ADDR_W'(1));
    grp    = {1'b0, k} >> stage;
    a      = (grp << ({1'b0, stage} + 3'd1)) + pos;
    b      = a + span;
    tw_idx = pos[TW_W-1:0] << (2'd3 - stage);
  end

endmodule

// File: rtl/fft16_bf_sched.sv
// Butterfly sequencer for the in-place 16-point radix-2 DIT FFT: issues reads and twiddle
// indices, replays the address pair as write-back after the read+butterfly latency.
module fft16_bf_sched
  import fft16_pkg::*;
#(
  parameter int RD_LAT = RD_LAT_DEF,
  parameter int BF_LAT = BF_LAT_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stall,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr0,
  output logic [ADDR_W-1:0] rd_addr1,
  output logic [TW_W-1:0]   tw_idx,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr0,
  output logic [ADDR_W-1:0] wr_addr1,
  output logic [1:0]        stage,
  output logic              busy,
  output logic              done
);

  localparam int WB_DLY = RD_LAT + BF_LAT;

  state_t            state_reg;
  logic [2:0]        k_reg;
  logic [1:0]        stage_reg;
  logic              busy_reg;
  logic              done_reg;

  logic              issue;
  logic              drained;
  logic [ADDR_W-1:0] gen_a;
  logic [ADDR_W-1:0] gen_b;
  logic [TW_W-1:0]   gen_tw;

  logic [WB_DLY-1:0] wb_valid_reg;
  logic [ADDR_W-1:0] wb_a_reg [WB_DLY];
  logic [ADDR_W-1:0] wb_b_reg [WB_DLY];

  fft16_addr_gen u_addr_gen (
    .stage  (stage_reg),
    .k      (k_reg),
    .a      (gen_a),
    .b      (gen_b),
    .tw_idx (gen_tw)
  );

  // stall gates the issue in the same cycle, since the RAM port is busy right now
  always_comb begin
    issue = (state_reg == ISSUE) && !stall;
  end

  assign rd_en    = issue;
  assign rd_addr0 = issue ? gen_a  : '0;
  assign rd_addr1 = issue ? gen_b  : '0;
  assign tw_idx   = issue ? gen_tw : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wb_valid_reg <= '0;
      for (int i = 0; i < WB_DLY; i++) begin
        wb_a_reg[i] <= '0;
        wb_b_reg[i] <= '0;
      end
    end else begin
      wb_valid_reg <= {wb_valid_reg[WB_DLY-2:0], issue};
      wb_a_reg[0]  <= rd_addr0;
      wb_b_reg[0]  <= rd_addr1;
      for (int i = 1; i < WB_DLY; i++) begin
        wb_a_reg[i] <= wb_a_reg[i-1];
        wb_b_reg[i] <= wb_b_reg[i-1];
      end
    end
  end

  assign wr_en    = wb_valid_reg[WB_DLY-1];
  assign wr_addr0 = wb_a_reg[WB_DLY-1];
  assign wr_addr1 = wb_b_reg[WB_DLY-1];

  // Only the tail may still be valid: that write lands this cycle, so the next read is safe
  assign drained = ~|wb_valid_reg[WB_DLY-2:0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= IDLE;
      k_reg     <= '0;
      stage_reg <= '0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          done_reg  <= 1'b0;
          stage_reg <= '0;
          k_reg     <= '0;
          if (start) begin
            state_reg <= ISSUE;
            busy_reg  <= 1'b1;
          end
        end
        ISSUE: begin
          if (!stall) begin
            k_reg <= k_reg + 3'd1;
            if (k_reg == 3'(NBF - 1)) begin
              state_reg <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (drained) begin
            k_reg <= '0;
            if (stage_reg == 2'(LOG2N - 1)) begin
              state_reg <= DONE;
              busy_reg  <= 1'b0;
              done_reg  <= 1'b1;
            end else begin
              stage_reg <= stage_reg + 2'd1;
              state_reg <= ISSUE;
            end
          end
        end
        DONE: begin
          done_reg  <= 1'b0;
          stage_reg <= '0;
          state_reg <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign stage = stage_reg;
  assign busy  = busy_reg;
  assign done  = done_reg;

endmodule
